// File: rtl/sram_axi_pkg.sv
// sram_axi_pkg: shared AXI constants, port state and request record types for the SRAM-to-AXI crossbar.
package sram_axi_pkg;
    localparam int ID_W = 4;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_WORD = 3'd2;
    typedef enum logic [1:0] {P_IDLE, P_RD_WAIT, P_WR_WAIT} port_state_e;
    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     addr;
        logic [7:0]      len;
        logic [2:0]      size;
    } ar_req_t;
    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     addr;
        logic [2:0]      size;
        logic [3:0]      strb;
        logic [31:0]     data;
    } wr_buf_t;
endpackage

// File: rtl/sram_axi_xbar_rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter; pointer moves past the granted requester.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);
    logic [IW-1:0] ptr_q, ptr_d;
    always_comb begin
        gnt_idx = ptr_q;
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(ptr_q) + k) % N]) gnt_idx = IW'((int'(ptr_q) + k) % N);
        gnt = |req ? N'(1) << gnt_idx : '0;
        ptr_d = |req ? (gnt_idx == IW'(N - 1) ? '0 : gnt_idx + IW'(1)) : ptr_q;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr_q <= '0;
        else ptr_q <= ptr_d;
endmodule

// File: rtl/sram_axi_xbar.sv
// sram_axi_xbar: NUM_PORTS SRAM-like ports arbitrated round-robin onto one AXI3 master.
module sram_axi_xbar
    import sram_axi_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int LINE_WORDS = 8
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [NUM_PORTS-1:0]    p_req,
    input  logic [NUM_PORTS-1:0]    p_wr,
    input  logic [NUM_PORTS-1:0]    p_cached,
    input  logic [2*NUM_PORTS-1:0]  p_size,
    input  logic [4*NUM_PORTS-1:0]  p_wstrb,
    input  logic [32*NUM_PORTS-1:0] p_addr,
    input  logic [32*NUM_PORTS-1:0] p_wdata,
    output logic [NUM_PORTS-1:0]    p_addr_ok,
    output logic [NUM_PORTS-1:0]    p_data_ok,
    output logic [NUM_PORTS-1:0]    p_rlast,
    output logic [31:0]             p_rdata,
    output logic [3:0]              arid,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic [1:0]              arlock,
    output logic [3:0]              arcache,
    output logic [2:0]              arprot,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [3:0]              rid,
    input  logic [31:0]             rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [3:0]              awid,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic [1:0]              awlock,
    output logic [3:0]              awcache,
    output logic [2:0]              awprot,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [3:0]              wid,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [3:0]              bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);
    localparam int IW = $clog2(NUM_PORTS);
    localparam int LB = $clog2(4 * LINE_WORDS);

    port_state_e st_q [NUM_PORTS];
    port_state_e st_d [NUM_PORTS];
    ar_req_t ar_q, ar_d;
    wr_buf_t wb_q, wb_d;
    logic ar_valid_q, ar_valid_d, wb_valid_q, wb_valid_d;
    logic aw_valid_q, aw_valid_d, w_valid_q, w_valid_d;
    logic [NUM_PORTS-1:0] elig, gnt;
    logic [IW-1:0] gnt_idx;
    logic [31:0] s_addr;
    logic [1:0] s_size;
    logic s_cached, s_rd, s_wr, ar_busy, wb_live;
    logic unused_resp;

    rr_arbiter #(.N(NUM_PORTS)) u_arb (
        .clk(aclk), .rst_n(aresetn), .req(elig), .gnt(gnt), .gnt_idx(gnt_idx)
    );

    always_comb begin
        ar_busy = ar_valid_q && !arready;
        // A completing write no longer hazards, so a blocked read may go in the bvalid cycle.
        wb_live = wb_valid_q && !bvalid;
        for (int i = 0; i < NUM_PORTS; i++)
            elig[i] = aresetn && st_q[i] == P_IDLE && p_req[i] && (p_wr[i] ? !wb_valid_q :
                !ar_busy && !(wb_live && (p_cached[i] ?
                    p_addr[32*i+LB +: 32-LB] == wb_q.addr[31:LB] :
                    p_addr[32*i+2 +: 30] == wb_q.addr[31:2])));
        s_addr = p_addr[32*gnt_idx +: 32];
        s_size = p_size[2*gnt_idx +: 2];
        s_cached = p_cached[gnt_idx];
        s_rd = |gnt && !p_wr[gnt_idx];
        s_wr = |gnt && p_wr[gnt_idx];
        ar_valid_d = s_rd || ar_busy;
        ar_d = ar_q;
        if (s_rd)
            ar_d = '{id: ID_W'(gnt_idx), addr: s_cached ? {s_addr[31:LB], LB'(0)} : s_addr,
                     len: s_cached ? 8'(LINE_WORDS - 1) : 8'd0,
                     size: s_cached ? AXI_SIZE_WORD : {1'b0, s_size}};
        wb_valid_d = s_wr || wb_live;
        aw_valid_d = s_wr || (aw_valid_q && !awready);
        w_valid_d = s_wr || (w_valid_q && !wready);
        wb_d = wb_q;
        if (s_wr)
            wb_d = '{id: ID_W'(gnt_idx), addr: s_addr, size: {1'b0, s_size},
                     strb: p_wstrb[4*gnt_idx +: 4], data: p_wdata[32*gnt_idx +: 32]};
        for (int i = 0; i < NUM_PORTS; i++) begin
            st_d[i] = gnt[i] ? (p_wr[i] ? P_WR_WAIT : P_RD_WAIT) :
                      ((rvalid && rlast && rid == ID_W'(i)) || (bvalid && bid == ID_W'(i))) ? P_IDLE : st_q[i];
            p_data_ok[i] = aresetn && ((rvalid && rid == ID_W'(i)) || (bvalid && bid == ID_W'(i)));
            p_rlast[i] = aresetn && rvalid && rlast && rid == ID_W'(i);
        end
    end

    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            for (int i = 0; i < NUM_PORTS; i++) st_q[i] <= P_IDLE;
            ar_q <= '0;
            wb_q <= '0;
            ar_valid_q <= 1'b0;
            wb_valid_q <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q <= 1'b0;
        end else begin
            st_q <= st_d;
            ar_q <= ar_d;
            wb_q <= wb_d;
            ar_valid_q <= ar_valid_d;
            wb_valid_q <= wb_valid_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q <= w_valid_d;
        end

    assign p_addr_ok = gnt;
    assign p_rdata = rdata;
    assign {arid, araddr, arlen, arsize} = {ar_q.id, ar_q.addr, ar_q.len, ar_q.size};
    assign arburst = AXI_BURST_INCR;
    assign arvalid = ar_valid_q;
    assign {arlock, arcache, arprot} = '0;
    assign rready = 1'b1;
    assign {awid, awaddr, awlen, awsize} = {wb_q.id, wb_q.addr, 8'd0, wb_q.size};
    assign awburst = AXI_BURST_INCR;
    assign awvalid = aw_valid_q;
    assign {awlock, awcache, awprot} = '0;
    assign {wid, wdata, wstrb, wlast} = {wb_q.id, wb_q.data, wb_q.strb, 1'b1};
    assign wvalid = w_valid_q;
    assign bready = 1'b1;
    assign unused_resp = ^{rresp, bresp};
endmodule

// File: tb/tb_sram_axi_xbar.sv
// tb_sram_axi_xbar: directed scenario tasks against a hand-driven AXI slave for sram_axi_xbar.
module tb_sram_axi_xbar;
    localparam int N = 2;
    logic aclk = 1'b0, aresetn;
    logic [N-1:0] p_req, p_wr, p_cached, p_addr_ok, p_data_ok, p_rlast;
    logic [2*N-1:0] p_size;
    logic [4*N-1:0] p_wstrb;
    logic [32*N-1:0] p_addr, p_wdata;
    logic [31:0] p_rdata, araddr, rdata, awaddr, wdata;
    logic [3:0] arid, arcache, rid, awid, awcache, wid, wstrb, bid;
    logic [7:0] arlen, awlen;
    logic [2:0] arsize, arprot, awsize, awprot;
    logic [1:0] arburst, arlock, rresp, awburst, awlock, bresp;
    logic arvalid, arready, rlast, rvalid, rready, awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    int n_checks = 0, n_fail = 0;

    sram_axi_xbar #(.NUM_PORTS(N), .LINE_WORDS(8)) dut (
        .aclk(aclk), .aresetn(aresetn), .p_req(p_req), .p_wr(p_wr), .p_cached(p_cached),
        .p_size(p_size), .p_wstrb(p_wstrb), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_addr_ok(p_addr_ok), .p_data_ok(p_data_ok), .p_rlast(p_rlast), .p_rdata(p_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic set_req(input int p, input logic wr, input logic cached, input logic [31:0] addr, input logic [31:0] data);
        p_req[p] = 1'b1; p_wr[p] = wr; p_cached[p] = cached; p_size[2*p +: 2] = 2'd2;
        p_wstrb[4*p +: 4] = 4'hF; p_addr[32*p +: 32] = addr; p_wdata[32*p +: 32] = data;
    endtask

    task automatic beat(input logic [3:0] id, input logic [31:0] d, input logic last);
        rvalid = 1'b1; rid = id; rdata = d; rlast = last;
    endtask

    task automatic test_reset();
        p_req = 2'b11; beat(4'd0, 32'h1234_5678, 1'b1);
        step(); #1;
        n_checks++; if (p_addr_ok !== 2'b00) begin n_fail++; $display("FAIL reset_addr_ok: got %b exp 00", p_addr_ok); end
        n_checks++; if (p_data_ok !== 2'b00) begin n_fail++; $display("FAIL reset_data_ok: got %b exp 00", p_data_ok); end
        n_checks++; if ({arvalid, awvalid, wvalid} !== 3'b000) begin n_fail++; $display("FAIL reset_valids: got %b exp 000", {arvalid, awvalid, wvalid}); end
        n_checks++; if ({rready, bready} !== 2'b11) begin n_fail++; $display("FAIL reset_readies: got %b exp 11", {rready, bready}); end
        p_req = '0; rvalid = 1'b0;
        step(); aresetn = 1'b1;
        step();
    endtask

    task automatic test_uncached_read();
        set_req(0, 1'b0, 1'b0, 32'h1000, 32'h0); #1;
        n_checks++; if (p_addr_ok !== 2'b01) begin n_fail++; $display("FAIL ur_addr_ok: got %b exp 01", p_addr_ok); end
        step(); p_req = '0; arready = 1'b1; #1;
        n_checks++; if ({arvalid, araddr, arlen, arid, arsize, arburst} !== {1'b1, 32'h1000, 8'd0, 4'd0, 3'd2, 2'b01})
            begin n_fail++; $display("FAIL ur_ar: got %b %h %0d %0d %0d %b exp 1 1000 0 0 2 01", arvalid, araddr, arlen, arid, arsize, arburst); end
        step(); #1;
        n_checks++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL ur_ar_drop: got %b exp 0", arvalid); end
        beat(4'd0, 32'hA5A5_A5A5, 1'b1); #1;
        n_checks++; if ({p_data_ok, p_rlast, p_rdata} !== {2'b01, 2'b01, 32'hA5A5_A5A5})
            begin n_fail++; $display("FAIL ur_data: got %b %b %h exp 01 01 a5a5a5a5", p_data_ok, p_rlast, p_rdata); end
        step(); rvalid = 1'b0;
    endtask

    task automatic test_cached_read();
        set_req(1, 1'b0, 1'b1, 32'h2014, 32'h0); #1;
        n_checks++; if (p_addr_ok !== 2'b10) begin n_fail++; $display("FAIL cr_addr_ok: got %b exp 10", p_addr_ok); end
        step(); p_req = '0; #1;
        n_checks++; if ({arvalid, araddr, arlen, arid, arsize} !== {1'b1, 32'h2000, 8'd7, 4'd1, 3'd2})
            begin n_fail++; $display("FAIL cr_ar: got %b %h %0d %0d %0d exp 1 2000 7 1 2", arvalid, araddr, arlen, arid, arsize); end
        step();
        for (int b = 0; b < 8; b++) begin
            beat(4'd1, 32'h2000_0000 + b, b == 7); #1;
            n_checks++; if ({p_data_ok, p_rlast, p_rdata} !== {2'b10, (b == 7) ? 2'b10 : 2'b00, 32'h2000_0000 + b})
                begin n_fail++; $display("FAIL cr_beat%0d: got %b %b %h", b, p_data_ok, p_rlast, p_rdata); end
            step();
        end
        rvalid = 1'b0;
    endtask

    task automatic test_round_robin();
        arready = 1'b0;
        set_req(0, 1'b0, 1'b0, 32'h100, 32'h0); set_req(1, 1'b0, 1'b0, 32'h200, 32'h0); #1;
        n_checks++; if (p_addr_ok !== 2'b01) begin n_fail++; $display("FAIL rr_first: got %b exp 01", p_addr_ok); end
        step(); p_req[0] = 1'b0; #1;
        n_checks++; if (p_addr_ok !== 2'b00) begin n_fail++; $display("FAIL rr_ar_busy: got %b exp 00", p_addr_ok); end
        step(); #1;
        n_checks++; if ({p_addr_ok, arid} !== {2'b00, 4'd0}) begin n_fail++; $display("FAIL rr_hold: got %b id %0d exp 00 id 0", p_addr_ok, arid); end
        arready = 1'b1; #1;
        n_checks++; if (p_addr_ok !== 2'b10) begin n_fail++; $display("FAIL rr_second: got %b exp 10", p_addr_ok); end
        step(); p_req[1] = 1'b0; #1;
        n_checks++; if ({arvalid, arid, araddr} !== {1'b1, 4'd1, 32'h200}) begin n_fail++; $display("FAIL rr_ar1: got %b %0d %h exp 1 1 200", arvalid, arid, araddr); end
        beat(4'd0, 32'h0A0A_0A0A, 1'b1); #1;
        n_checks++; if ({p_data_ok, p_rdata} !== {2'b01, 32'h0A0A_0A0A}) begin n_fail++; $display("FAIL rr_ret0: got %b %h", p_data_ok, p_rdata); end
        step(); beat(4'd1, 32'h1111_1111, 1'b1); #1;
        n_checks++; if ({p_data_ok, p_rdata} !== {2'b10, 32'h1111_1111}) begin n_fail++; $display("FAIL rr_ret1: got %b %h", p_data_ok, p_rdata); end
        step(); rvalid = 1'b0;
    endtask

    task automatic test_out_of_order();
        set_req(0, 1'b0, 1'b0, 32'h6000, 32'h0); set_req(1, 1'b0, 1'b0, 32'h7000, 32'h0); #1;
        n_checks++; if (p_addr_ok !== 2'b01) begin n_fail++; $display("FAIL oo_grant0: got %b exp 01", p_addr_ok); end
        step(); p_req[0] = 1'b0; #1;
        n_checks++; if ({p_addr_ok, arid} !== {2'b10, 4'd0}) begin n_fail++; $display("FAIL oo_grant1: got %b id %0d exp 10 id 0", p_addr_ok, arid); end
        step(); p_req[1] = 1'b0; #1;
        n_checks++; if ({arid, araddr} !== {4'd1, 32'h7000}) begin n_fail++; $display("FAIL oo_ar1: got %0d %h exp 1 7000", arid, araddr); end
        step(); beat(4'd1, 32'h7777_0001, 1'b1); #1;
        n_checks++; if ({p_data_ok, p_rlast, p_rdata} !== {2'b10, 2'b10, 32'h7777_0001}) begin n_fail++; $display("FAIL oo_ret1: got %b %b %h", p_data_ok, p_rlast, p_rdata); end
        step(); beat(4'd0, 32'h6666_0000, 1'b1); #1;
        n_checks++; if ({p_data_ok, p_rlast, p_rdata} !== {2'b01, 2'b01, 32'h6666_0000}) begin n_fail++; $display("FAIL oo_ret0: got %b %b %h", p_data_ok, p_rlast, p_rdata); end
        step(); rvalid = 1'b0;
    endtask

    task automatic test_write_hazard();
        awready = 1'b1; wready = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h3000, 32'hDEAD_BEEF); #1;
        n_checks++; if (p_addr_ok !== 2'b01) begin n_fail++; $display("FAIL wr_addr_ok: got %b exp 01", p_addr_ok); end
        step(); p_req = '0; #1;
        n_checks++; if ({awvalid, wvalid, awaddr, awlen, awid, awsize, awburst, wid, wdata, wstrb, wlast} !==
                        {2'b11, 32'h3000, 8'd0, 4'd0, 3'd2, 2'b01, 4'd0, 32'hDEAD_BEEF, 4'hF, 1'b1})
            begin n_fail++; $display("FAIL wr_aw_w: got %b%b %h %0d %0d %0d %b %0d %h %h %b", awvalid, wvalid, awaddr, awlen, awid, awsize, awburst, wid, wdata, wstrb, wlast); end
        step(); #1;
        n_checks++; if ({awvalid, wvalid} !== 2'b01) begin n_fail++; $display("FAIL wr_indep: got %b exp 01", {awvalid, wvalid}); end
        wready = 1'b1; step(); #1;
        n_checks++; if (wvalid !== 1'b0) begin n_fail++; $display("FAIL wr_w_drop: got %b exp 0", wvalid); end
        set_req(1, 1'b0, 1'b0, 32'h3010, 32'h0); #1;
        n_checks++; if (p_addr_ok !== 2'b10) begin n_fail++; $display("FAIL wr_nohaz: got %b exp 10", p_addr_ok); end
        step(); p_req = '0; step(); beat(4'd1, 32'h3010_3010, 1'b1); #1;
        n_checks++; if (p_data_ok !== 2'b10) begin n_fail++; $display("FAIL wr_nohaz_data: got %b exp 10", p_data_ok); end
        step(); rvalid = 1'b0; set_req(1, 1'b0, 1'b0, 32'h3000, 32'h0); #1;
        n_checks++; if (p_addr_ok !== 2'b00) begin n_fail++; $display("FAIL wr_haz0: got %b exp 00", p_addr_ok); end
        step(); #1;
        n_checks++; if (p_addr_ok !== 2'b00) begin n_fail++; $display("FAIL wr_haz1: got %b exp 00", p_addr_ok); end
        bvalid = 1'b1; bid = 4'd0; #1;
        n_checks++; if ({p_addr_ok, p_data_ok, p_rlast} !== {2'b10, 2'b01, 2'b00}) begin n_fail++; $display("FAIL wr_bvalid: got %b %b %b exp 10 01 00", p_addr_ok, p_data_ok, p_rlast); end
        step(); bvalid = 1'b0; p_req = '0; #1;
        n_checks++; if ({arvalid, araddr} !== {1'b1, 32'h3000}) begin n_fail++; $display("FAIL wr_ar_after: got %b %h exp 1 3000", arvalid, araddr); end
        step(); beat(4'd1, 32'h3000_0000, 1'b1); step(); rvalid = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        arready = 1'b0;
        set_req(1, 1'b0, 1'b1, 32'h8000, 32'h0); #1;
        n_checks++; if (p_addr_ok !== 2'b10) begin n_fail++; $display("FAIL mr_addr_ok: got %b exp 10", p_addr_ok); end
        step(); p_req = '0; beat(4'd1, 32'h8000_0000, 1'b0); #1;
        n_checks++; if ({arvalid, p_data_ok} !== {1'b1, 2'b10}) begin n_fail++; $display("FAIL mr_pre: got %b %b exp 1 10", arvalid, p_data_ok); end
        step(); beat(4'd1, 32'h8000_0001, 1'b0); #1;
        aresetn = 1'b0; #1;
        n_checks++; if ({arvalid, awvalid, wvalid, p_data_ok, p_rlast, p_addr_ok} !== 9'd0)
            begin n_fail++; $display("FAIL mr_async: got %b %b %b %b %b %b", arvalid, awvalid, wvalid, p_data_ok, p_rlast, p_addr_ok); end
        rvalid = 1'b0; step(); aresetn = 1'b1; step();
        set_req(1, 1'b0, 1'b0, 32'h5000, 32'h0); #1;
        n_checks++; if (p_addr_ok !== 2'b10) begin n_fail++; $display("FAIL mr_fresh_grant: got %b exp 10", p_addr_ok); end
        step(); p_req = '0; arready = 1'b1; #1;
        n_checks++; if ({arvalid, araddr, arlen, arid} !== {1'b1, 32'h5000, 8'd0, 4'd1}) begin n_fail++; $display("FAIL mr_fresh_ar: got %b %h %0d %0d", arvalid, araddr, arlen, arid); end
        step(); beat(4'd1, 32'h5A5A_5A5A, 1'b1); #1;
        n_checks++; if ({p_data_ok, p_rlast, p_rdata} !== {2'b10, 2'b10, 32'h5A5A_5A5A}) begin n_fail++; $display("FAIL mr_fresh_data: got %b %b %h", p_data_ok, p_rlast, p_rdata); end
        step(); rvalid = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0;
        p_req = '0; p_wr = '0; p_cached = '0; p_size = '0; p_wstrb = '0; p_addr = '0; p_wdata = '0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
        test_reset();
        test_uncached_read();
        test_cached_read();
        test_round_robin();
        test_out_of_order();
        test_write_hazard();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
